// File: rtl/clk_gen_monitor.sv
// Clock health monitor: samples MON_CLK in the CLK domain, measures its period and
// high time in CLK cycles, flags period/duty violations and a stuck clock, and reports lock.
module clk_gen_monitor #(
  parameter int CNT_WIDTH  = 16,
  parameter int EXP_PERIOD = 10,
  parameter int PERIOD_TOL = 1,
  parameter int EXP_HIGH   = 5,
  parameter int HIGH_TOL   = 1,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 EN,
  input  logic                 MON_CLK,
  input  logic                 ERR_CLR,
  output logic [CNT_WIDTH-1:0] PERIOD_OUT,
  output logic [CNT_WIDTH-1:0] HIGH_OUT,
  output logic                 MEAS_VALID,
  output logic                 PERIOD_ERR,
  output logic                 DUTY_ERR,
  output logic                 STUCK,
  output logic                 LOCKED
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] EXP_P  = CNT_WIDTH'(EXP_PERIOD);
  localparam logic [CNT_WIDTH-1:0] TOL_P  = CNT_WIDTH'(PERIOD_TOL);
  localparam logic [CNT_WIDTH-1:0] EXP_H  = CNT_WIDTH'(EXP_HIGH);
  localparam logic [CNT_WIDTH-1:0] TOL_H  = CNT_WIDTH'(HIGH_TOL);
  localparam logic [CNT_WIDTH-1:0] TMO    = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
  localparam logic [GOOD_W-1:0]    LOCK_N = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_e;

  state_e                 state_q, state_d;
  logic                   s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic [CNT_WIDTH-1:0]   period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
  logic                   high_run_q, high_run_d;
  logic [GOOD_W-1:0]      good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0]   period_out_q, period_out_d, high_out_q, high_out_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   period_err_q, period_err_d, duty_err_q, duty_err_d;
  logic                   stuck_q, stuck_d, locked_q, locked_d;
  logic                   rise, fall, period_bad, high_bad;

  function automatic logic [CNT_WIDTH-1:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  assign period_bad = abs_diff(period_cnt_q, EXP_P) > TOL_P;
  // A high_run still set at the closing rise means no fall was seen this period.
  assign high_bad   = (abs_diff(high_cnt_q, EXP_H) > TOL_H) || high_run_q;

  always_comb begin
    // NOTE: every variable gets its hold/default value first, so no path can infer a latch.
    state_d      = state_q;
    s1_d         = MON_CLK;
    s2_d         = s1_q;
    s3_d         = s2_q;
    period_cnt_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + ONE;
    high_cnt_d   = high_cnt_q;
    high_run_d   = high_run_q;
    good_cnt_d   = good_cnt_q;
    period_out_d = period_out_q;
    high_out_d   = high_out_q;
    meas_valid_d = 1'b0;
    period_err_d = period_err_q & ~ERR_CLR;
    duty_err_d   = duty_err_q & ~ERR_CLR;
    stuck_d      = stuck_q;
    locked_d     = locked_q;

    if (high_run_q && !fall && high_cnt_q != '1) high_cnt_d = high_cnt_q + ONE;
    if (fall) high_run_d = 1'b0;

    if (!EN) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      high_run_d   = 1'b0;
      good_cnt_d   = '0;
      stuck_d      = 1'b0;
      locked_d     = 1'b0;
    end else if (state_q == IDLE) begin
      state_d      = WAIT_RISE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      high_run_d   = 1'b0;
    end else if (rise) begin
      state_d      = MEASURE;
      period_cnt_d = ONE;
      high_cnt_d   = ONE;
      high_run_d   = 1'b1;
      stuck_d      = 1'b0;
      if (state_q == MEASURE) begin
        period_out_d = period_cnt_q;
        high_out_d   = high_cnt_q;
        meas_valid_d = 1'b1;
        if (period_bad) period_err_d = 1'b1;
        if (high_bad)   duty_err_d   = 1'b1;
        if (period_bad || high_bad) begin
          good_cnt_d = '0;
          locked_d   = 1'b0;
        end else begin
          if (good_cnt_q != LOCK_N) good_cnt_d = good_cnt_q + GOOD_W'(1);
          if (good_cnt_d == LOCK_N) locked_d = 1'b1;
        end
      end
    end else if (period_cnt_q == TMO) begin
      state_d      = WAIT_RISE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      high_run_d   = 1'b0;
      good_cnt_d   = '0;
      stuck_d      = 1'b1;
      locked_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      high_run_q   <= 1'b0;
      good_cnt_q   <= '0;
      period_out_q <= '0;
      high_out_q   <= '0;
      meas_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      duty_err_q   <= 1'b0;
      stuck_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      high_run_q   <= high_run_d;
      good_cnt_q   <= good_cnt_d;
      period_out_q <= period_out_d;
      high_out_q   <= high_out_d;
      meas_valid_q <= meas_valid_d;
      period_err_q <= period_err_d;
      duty_err_q   <= duty_err_d;
      stuck_q      <= stuck_d;
      locked_q     <= locked_d;
    end
  end

  assign PERIOD_OUT = period_out_q;
  assign HIGH_OUT   = high_out_q;
  assign MEAS_VALID = meas_valid_q;
  assign PERIOD_ERR = period_err_q;
  assign DUTY_ERR   = duty_err_q;
  assign STUCK      = stuck_q;
  assign LOCKED     = locked_q;

endmodule

// File: tb/tb_clk_gen_monitor.sv
// Self-checking bench for clk_gen_monitor: directed vector table, hand-written
// stuck/enable/reset sequences, and randomized waveforms against a period-list model.
module tb_clk_gen_monitor;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        EN = 1'b0;
  logic        MON_CLK = 1'b0;
  logic        ERR_CLR = 1'b0;
  logic [15:0] PERIOD_OUT, HIGH_OUT;
  logic        MEAS_VALID, PERIOD_ERR, DUTY_ERR, STUCK, LOCKED;

  clk_gen_monitor dut (
    .CLK(CLK), .RESETN(RESETN), .EN(EN), .MON_CLK(MON_CLK), .ERR_CLR(ERR_CLR),
    .PERIOD_OUT(PERIOD_OUT), .HIGH_OUT(HIGH_OUT), .MEAS_VALID(MEAS_VALID),
    .PERIOD_ERR(PERIOD_ERR), .DUTY_ERR(DUTY_ERR), .STUCK(STUCK), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    int p; int h; bit perr; bit derr; bit lock; int cyc;
  } meas_t;
  meas_t mq[$];

  // One directed MON_CLK period plus the measurement its rising edge should report.
  typedef struct {
    int per; int hi; bit clr;
    bit has; int p; int h; bit perr; bit derr; bit lock;
  } vec_t;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    if (MEAS_VALID) mq.push_back('{int'(PERIOD_OUT), int'(HIGH_OUT), PERIOD_ERR, DUTY_ERR, LOCKED, cyc});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int p, input int h, input bit a, input bit b, input bit c);
    return {29'd0, 16'(p), 16'(h), a, b, c};
  endfunction

  task automatic check_meas(input string name, input int idx, input int p, input int h,
                            input bit perr, input bit derr, input bit lock);
    if (idx < mq.size())
      check(name, pk(mq[idx].p, mq[idx].h, mq[idx].perr, mq[idx].derr, mq[idx].lock),
            pk(p, h, perr, derr, lock));
    else
      check({name, " missing"}, 64'(mq.size()), 64'(idx + 1));
  endtask

  // Drives one MON_CLK period synchronously; optional ERR_CLR lands on the cycle
  // in which this period's rising edge is evaluated.
  task automatic drive_seg(input int per, input int hi, input bit clr);
    for (int c = 0; c < per; c++) begin
      @(negedge CLK);
      MON_CLK = (c < hi);
      ERR_CLR = clr && (c == 2);
    end
    ERR_CLR = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    wait_neg(2);
    RESETN = 1'b1;
    wait_neg(2);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    int   base, last_cyc, n;
    int   sp[40], sh[40];
    bit   perr_m, derr_m;
    int   run;

    tbl[0]  = '{10, 5, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{10, 5, 0, 1, 10, 5, 0, 0, 0};
    tbl[2]  = '{10, 5, 0, 1, 10, 5, 0, 0, 0};
    tbl[3]  = '{10, 5, 0, 1, 10, 5, 0, 0, 0};
    tbl[4]  = '{10, 5, 0, 1, 10, 5, 0, 0, 1};
    tbl[5]  = '{13, 5, 0, 1, 10, 5, 0, 0, 1};
    tbl[6]  = '{10, 5, 0, 1, 13, 5, 1, 0, 0};
    tbl[7]  = '{10, 5, 0, 1, 10, 5, 1, 0, 0};
    tbl[8]  = '{10, 5, 0, 1, 10, 5, 1, 0, 0};
    tbl[9]  = '{10, 5, 0, 1, 10, 5, 1, 0, 0};
    tbl[10] = '{10, 5, 1, 1, 10, 5, 0, 0, 1};
    tbl[11] = '{10, 8, 0, 1, 10, 5, 0, 0, 1};
    tbl[12] = '{10, 8, 0, 1, 10, 8, 0, 1, 0};
    tbl[13] = '{10, 5, 1, 1, 10, 8, 0, 1, 0};
    tbl[14] = '{10, 5, 0, 1, 10, 5, 0, 1, 0};
    tbl[15] = '{10, 5, 0, 1, 10, 5, 0, 1, 0};
    tbl[16] = '{10, 5, 0, 1, 10, 5, 0, 1, 0};
    tbl[17] = '{10, 5, 0, 1, 10, 5, 0, 1, 1};

    // Reset state
    wait_neg(3);
    check("reset_outputs", {PERIOD_OUT, HIGH_OUT, MEAS_VALID, PERIOD_ERR, DUTY_ERR, STUCK, LOCKED}, '0);
    RESETN = 1'b1;
    EN     = 1'b1;
    wait_neg(2);

    // Directed table: nominal lock, period error, ERR_CLR, duty error, clear-vs-set
    base = mq.size();
    foreach (tbl[i]) drive_seg(tbl[i].per, tbl[i].hi, tbl[i].clr);
    check("table_meas_count", 64'(mq.size() - base), 64'd17);
    n = base;
    foreach (tbl[i])
      if (tbl[i].has) begin
        check_meas($sformatf("table[%0d]", i), n, tbl[i].p, tbl[i].h, tbl[i].perr, tbl[i].derr, tbl[i].lock);
        n++;
      end

    // Stuck clock: MON_CLK held low after lock
    base     = mq.size();
    last_cyc = (mq.size() > 0) ? mq[$].cyc : cyc;
    while (cyc < last_cyc + 63) @(negedge CLK);
    check("stuck_before_timeout", {STUCK, LOCKED}, 2'b01);
    @(negedge CLK);
    check("stuck_at_timeout", {STUCK, LOCKED}, 2'b10);
    check("stuck_no_meas", 64'(mq.size() - base), 64'd0);
    check("stuck_holds_period", 64'(PERIOD_OUT), 64'd10);

    // Resume: first rise clears STUCK and is discarded; lock rebuilt
    drive_seg(10, 5, 0);
    check("resume_stuck_clear", {STUCK, 1'b0}, 2'b00);
    check("resume_first_discarded", 64'(mq.size() - base), 64'd0);
    for (int i = 0; i < 4; i++) drive_seg(10, 5, 0);
    check("resume_meas_count", 64'(mq.size() - base), 64'd4);
    check_meas("resume_meas0", base, 10, 5, 0, 1, 0);
    check_meas("resume_meas3", base + 3, 10, 5, 0, 1, 1);
    check("resume_locked", 64'(LOCKED), 64'd1);

    // Drop EN mid-period after lock
    @(negedge CLK); MON_CLK = 1'b1;
    wait_neg(3);
    EN = 1'b0;
    @(negedge CLK);
    check("en_off_state", {LOCKED, STUCK, DUTY_ERR, PERIOD_OUT}, {1'b0, 1'b0, 1'b1, 16'd10});
    MON_CLK = 1'b0;
    wait_neg(5);
    EN = 1'b1;
    wait_neg(3);
    base = mq.size();
    for (int i = 0; i < 5; i++) drive_seg(10, 5, 0);
    check("reenable_meas_count", 64'(mq.size() - base), 64'd4);
    check_meas("reenable_meas2", base + 2, 10, 5, 0, 1, 0);
    check_meas("reenable_meas3", base + 3, 10, 5, 0, 1, 1);

    // Asynchronous reset between rise and fall
    @(negedge CLK); MON_CLK = 1'b1;
    @(negedge CLK);
    #3 RESETN = 1'b0;
    #1 check("async_reset_outputs",
             {PERIOD_OUT, HIGH_OUT, MEAS_VALID, PERIOD_ERR, DUTY_ERR, STUCK, LOCKED}, '0);
    MON_CLK = 1'b0;
    wait_neg(2);
    RESETN = 1'b1;
    wait_neg(2);
    base = mq.size();
    drive_seg(10, 5, 0);
    drive_seg(10, 5, 0);
    check("post_reset_meas_count", 64'(mq.size() - base), 64'd1);
    check_meas("post_reset_meas", base, 10, 5, 0, 0, 0);

    // Randomized waveforms against a period/high-time list model
    do_reset();
    foreach (sp[i]) begin
      if ($urandom_range(1, 0) == 1) begin
        sp[i] = $urandom_range(11, 9);
        sh[i] = $urandom_range(6, 4);
      end else begin
        sp[i] = $urandom_range(16, 6);
        sh[i] = $urandom_range(sp[i] - 2, 2);
      end
    end
    base = mq.size();
    foreach (sp[i]) drive_seg(sp[i], sh[i], 0);
    check("rand_meas_count", 64'(mq.size() - base), 64'd39);
    perr_m = 0; derr_m = 0; run = 0;
    for (int k = 0; k < 39; k++) begin
      int  dp, dh;
      bit  pbad, hbad;
      dp   = (sp[k] > 10) ? sp[k] - 10 : 10 - sp[k];
      dh   = (sh[k] > 5)  ? sh[k] - 5  : 5 - sh[k];
      pbad = dp > 1;
      hbad = dh > 1;
      perr_m |= pbad;
      derr_m |= hbad;
      run = (pbad || hbad) ? 0 : run + 1;
      check_meas($sformatf("rand[%0d] p=%0d h=%0d", k, sp[k], sh[k]), base + k,
                 sp[k], sh[k], perr_m, derr_m, run >= 4);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
